// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants and coordinate type.
// Used by the sync generator and the tile, bitmap and RGB blocks.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int CLK_DIV_DEF   = 4;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF =
    H_DISPLAY_DEF + H_FRONT_DEF +
    H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF =
    V_DISPLAY_DEF + V_FRONT_DEF +
    V_SYNC_DEF + V_BACK_DEF;

  localparam int HS_START_DEF =
    H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int HS_END_DEF =
    HS_START_DEF + H_SYNC_DEF - 1;
  localparam int VS_START_DEF =
    V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int VS_END_DEF =
    VS_START_DEF + V_SYNC_DEF - 1;

  // Inclusive range test used by the sync decoders.
  function automatic logic in_span(
    input coord_t v,
    input coord_t lo,
    input coord_t hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_pixel_tick_gen.sv
// pixel_tick_gen: divides clk by CLK_DIV into a one-clk pixel strobe.
// With CLK_DIV=1 the strobe is high on every clock.
module pixel_tick_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic p_tick
);

  localparam int W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST =
    W'(CLK_DIV - 1);

  logic [W-1:0] div_cnt_q;
  logic [W-1:0] div_cnt_d;

  assign p_tick = (div_cnt_q == LAST);

  // Divider count: 0..CLK_DIV-1, wrapping on the tick.
  always_comb begin
    div_cnt_d = div_cnt_q + W'(1);
    if (p_tick) div_cnt_d = '0;
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/vga_sync.sv
// vga_sync: free-running H/V scan counters with registered sync and
// video_on decoded from next-state counters so every output agrees.
module vga_sync
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_tick
);

  localparam int H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS  = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS  = coord_t'(V_DISPLAY);

  localparam coord_t HS_LO =
    coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_HI =
    coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_LO =
    coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_HI =
    coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  coord_t pixel_x_q, pixel_x_d;
  coord_t pixel_y_q, pixel_y_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   video_on_q, video_on_d;
  logic   h_wrap;
  logic   v_wrap;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .p_tick (p_tick)
  );

  assign h_wrap = (pixel_x_q == H_LAST);
  assign v_wrap = (pixel_y_q == V_LAST);

  // Next scan position plus the sync/video decode of that position.
  always_comb begin
    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    if (p_tick) begin
      if (h_wrap) begin
        pixel_x_d = '0;
        pixel_y_d = v_wrap ? '0 : pixel_y_q + 10'd1;
      end else begin
        pixel_x_d = pixel_x_q + 10'd1;
      end
    end
    hsync_d    = !in_span(pixel_x_d, HS_LO, HS_HI);
    vsync_d    = !in_span(pixel_y_d, VS_LO, VS_HI);
    video_on_d = (pixel_x_d < H_VIS) &&
                 (pixel_y_d < V_VIS);
  end

  // Counters and output registers share one edge; reset is (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_x_q  <= '0;
      pixel_y_q  <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b1;
    end else begin
      pixel_x_q  <= pixel_x_d;
      pixel_y_q  <= pixel_y_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign pixel_x    = pixel_x_q;
  assign pixel_y    = pixel_y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign frame_tick = p_tick & h_wrap & v_wrap;

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: directed table plus per-clock reference check on a
// shrunken 23x15 raster, at CLK_DIV=4 and CLK_DIV=1.
module tb_vga_sync;

  localparam int HD = 16, HF = 2, HS = 3, HB = 2;
  localparam int VD = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       ft;
  } out_t;

  typedef struct {
    int   c;
    out_t e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       pt4, hs4, vs4, von4, ft4;
  logic [9:0] x4, y4;
  logic       pt1, hs1, vs1, von1, ft1;
  logic [9:0] x1, y1;

  int n_tests = 0;
  int n_fail  = 0;
  int m_clk   = 0;
  bit chk_on  = 0;
  int von_cnt = 0, vs_lo = 0, hs_lo = 0;
  int ft_cnt  = 0, ft1_cnt = 0;

  vec_t vecs[16];

  always #5 clk = ~clk;

  vga_sync #(
    .CLK_DIV(4),
    .H_DISPLAY(HD), .H_FRONT(HF),
    .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF),
    .V_SYNC(VS), .V_BACK(VB)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .p_tick(pt4),
    .pixel_x(x4), .pixel_y(y4),
    .hsync(hs4), .vsync(vs4),
    .video_on(von4),
    .frame_tick(ft4)
  );

  vga_sync #(
    .CLK_DIV(1),
    .H_DISPLAY(HD), .H_FRONT(HF),
    .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF),
    .V_SYNC(VS), .V_BACK(VB)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .p_tick(pt1),
    .pixel_x(x1), .pixel_y(y1),
    .hsync(hs1), .vsync(vs1),
    .video_on(von1),
    .frame_tick(ft1)
  );

  function automatic out_t cur4();
    return '{x4, y4, hs4, vs4, von4, pt4, ft4};
  endfunction

  function automatic out_t cur1();
    return '{x1, y1, hs1, vs1, von1, pt1, ft1};
  endfunction

  // Reference: position from clocks elapsed since reset release.
  function automatic out_t model(input int c, input int div);
    out_t o;
    int n, x, y;
    n = c / div;
    x = n % HT;
    y = (n / HT) % VT;
    o.x   = 10'(x);
    o.y   = 10'(y);
    o.hs  = !(x >= HD + HF && x <= HD + HF + HS - 1);
    o.vs  = !(y >= VD + VF && y <= VD + VF + VS - 1);
    o.von = (x < HD) && (y < VD);
    o.pt  = ((c % div) == div - 1);
    o.ft  = o.pt && (x == HT - 1) && (y == VT - 1);
    return o;
  endfunction

  function automatic vec_t mk(
    input int c, input int x, input int y,
    input bit h, input bit v, input bit vo,
    input bit p, input bit f
  );
    vec_t r;
    r.c = c;
    r.e = '{10'(x), 10'(y), h, v, vo, p, f};
    return r;
  endfunction

  task automatic cmp(input string nm, input out_t g, input out_t e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b, need x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ft=%b",
               nm, g.x, g.y, g.hs, g.vs, g.von, g.pt, g.ft,
               e.x, e.y, e.hs, e.vs, e.von, e.pt, e.ft);
    end
  endtask

  task automatic cmp_int(input string nm, input int g, input int e);
    n_tests++;
    if (g != e) begin
      n_fail++;
      $display("FAIL %s: got %0d, need %0d", nm, g, e);
    end
  endtask

  task automatic wait_clk(input int c);
    int guard = 0;
    while (m_clk < c && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    cmp_int("wait_reach", m_clk, c);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_clk <= 0;
    else        m_clk <= m_clk + 1;
  end

  // Every clock: both DUTs against the reference; frame statistics.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("cyc_div4", cur4(), model(m_clk, 4));
      cmp("cyc_div1", cur1(), model(m_clk, 1));
      if (!rst_n) begin
        von_cnt = 0; vs_lo = 0; hs_lo = 0;
        ft_cnt = 0; ft1_cnt = 0;
      end else begin
        if (m_clk < 4 * HT * VT && pt4) begin
          von_cnt += int'(von4);
          vs_lo   += int'(!vs4);
          hs_lo   += int'(!hs4);
          ft_cnt  += int'(ft4);
        end
        if (m_clk < 2 * HT * VT)
          ft1_cnt += int'(ft1);
      end
    end
  end

  initial begin
    vecs[0]  = mk(0,    0,  0,  1, 1, 1, 0, 0);
    vecs[1]  = mk(3,    0,  0,  1, 1, 1, 1, 0);
    vecs[2]  = mk(4,    1,  0,  1, 1, 1, 0, 0);
    vecs[3]  = mk(63,   15, 0,  1, 1, 1, 1, 0);
    vecs[4]  = mk(64,   16, 0,  1, 1, 0, 0, 0);
    vecs[5]  = mk(72,   18, 0,  0, 1, 0, 0, 0);
    vecs[6]  = mk(83,   20, 0,  0, 1, 0, 1, 0);
    vecs[7]  = mk(84,   21, 0,  1, 1, 0, 0, 0);
    vecs[8]  = mk(91,   22, 0,  1, 1, 0, 1, 0);
    vecs[9]  = mk(92,   0,  1,  1, 1, 1, 0, 0);
    vecs[10] = mk(736,  0,  8,  1, 1, 0, 0, 0);
    vecs[11] = mk(920,  0,  10, 1, 0, 0, 0, 0);
    vecs[12] = mk(1100, 22, 11, 1, 0, 0, 0, 0);
    vecs[13] = mk(1104, 0,  12, 1, 1, 0, 0, 0);
    vecs[14] = mk(1379, 22, 14, 1, 1, 0, 1, 1);
    vecs[15] = mk(1380, 0,  0,  1, 1, 1, 0, 0);

    repeat (2) @(negedge clk);
    chk_on = 1;
    repeat (2) @(negedge clk);
    cmp("rst_hold_div4", cur4(), vecs[0].e);
    cmp_int("rst_hold_div1_pt", int'(pt1), 1);

    @(posedge clk);
    #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      wait_clk(vecs[i].c);
      cmp($sformatf("vec%0d", i), cur4(), vecs[i].e);
    end

    cmp_int("frame_von_ticks", von_cnt, HD * VD);
    cmp_int("frame_vs_low_ticks", vs_lo, VS * HT);
    cmp_int("frame_hs_low_ticks", hs_lo, HS * VT);
    cmp_int("frame_tick_count", ft_cnt, 1);
    cmp_int("div1_frame_ticks", ft1_cnt, 2);

    wait_clk(1500);
    cmp("mid_pos", cur4(), mk(0, 7, 1, 1, 1, 1, 0, 0).e);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_rst_div4", cur4(), vecs[0].e);
    cmp_int("async_rst_div1_x", int'(x1), 0);
    cmp_int("async_rst_div1_pt", int'(pt1), 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    wait_clk(3);
    cmp("resume_c3", cur4(), vecs[1].e);
    wait_clk(4);
    cmp("resume_c4", cur4(), vecs[2].e);
    cmp_int("resume_div1_x", int'(x1), 4);
    wait_clk(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
